ysyx_22040127_mem_arbiter: RTL
==============================

YSYX_22040127_MEM_ARBITER -- requirements
Module: ysyx_22040127_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: response-wait cycles before an error completion.
REQ-002 SHALL have parameter AW, default 64: address width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports if_req in 1, if_addr in AW, if_gnt out 1, if_rvalid out 1, if_rdata out 64, if_err out 1: fetch requester, read-only.
REQ-006 SHALL have ports d_req in 1, d_we in 1, d_addr in AW, d_wdata in 64, d_wmask in 8, d_gnt out 1, d_rvalid out 1, d_rdata out 64, d_err out 1: data requester, read or write.
REQ-007 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out AW, mem_wdata out 64, mem_wmask out 8, mem_gnt in 1, mem_rvalid in 1, mem_rdata in 64: shared memory port.

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE; one transaction outstanding at a time.
REQ-009 In IDLE with any request, SHALL select one owner, latch its addr/we/wdata/wmask (IF: we=0, wmask=0), pulse that requester's gnt for exactly that cycle, and enter ISSUE next cycle.
REQ-010 Requesters SHALL hold req and fields stable until gnt; after gnt they may drop or change them without effect on the latched transaction.
REQ-011 In ISSUE, SHALL drive mem_req=1 with latched fields; on mem_gnt=1 SHALL enter WAIT; mem_req SHALL be 0 in all other states.
REQ-012 In WAIT, on mem_rvalid=1 SHALL assert owner's rvalid for that same cycle with owner's rdata=mem_rdata, err=0, and return to IDLE next cycle.
REQ-013 Non-owner rvalid/err SHALL be 0; rdata outputs SHALL equal mem_rdata unconditionally (qualified by rvalid only).
REQ-014 Writes SHALL complete through mem_rvalid identically to reads; rdata is don't-care for writes.
REQ-015 SHALL count cycles in ISSUE+WAIT with an 8-bit-or-wider counter cleared on entering ISSUE; when it reaches TIMEOUT_CYC without mem_rvalid, SHALL pulse owner's rvalid and err for one cycle, rdata=0, and return to IDLE.
REQ-016 mem_rvalid arriving in IDLE or ISSUE SHALL be ignored.
REQ-017 Without RR (see Configuration), simultaneous if_req and d_req SHALL grant data requester (fixed priority).
REQ-018 gnt SHALL never be asserted outside IDLE; minimum spacing between grants is 3 cycles.

Reset
REQ-019 On rst=1, asynchronously: state=IDLE, counter=0, latched fields=0, owner=IF, rr pointer=IF; all outputs 0 (gnt, rvalid, err, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask).
REQ-020 Reset mid-transaction SHALL abandon it with no rvalid emitted; a late mem_rvalid after reset is ignored per REQ-016.

Configuration
REQ-021 Macro YSYX_22040127_ARB_RR_EN defined: simultaneous requests SHALL alternate, preferring the requester not granted last; pointer updates only on grant.
REQ-022 Macro undefined: fixed data priority per REQ-017; pointer logic absent.

Verification
REQ-023 Single IF read addr 0x80000000, mem_gnt immediate, mem_rvalid 2 cycles later with 0x00000013 -> if_gnt at cycle 0, mem_req at cycle 1, if_rvalid with rdata 0x13, d_rvalid=0.
REQ-024 d_req write addr 0x80001004, wdata 0xDEADBEEF, wmask 0xF0 -> mem_we=1, mem_wmask=0xF0, mem_addr=0x80001004 in ISSUE; d_rvalid on ack, if outputs idle.
REQ-025 if_req and d_req together held 4 transactions -> no RR: D,D,D,D while d_req held; with YSYX_22040127_ARB_RR_EN: D,IF,D,IF.
REQ-026 mem_rvalid never returned, TIMEOUT_CYC=8 -> owner rvalid+err pulse 8 cycles after ISSUE entry, rdata=0, FSM IDLE next cycle.
REQ-027 rst asserted in WAIT, mem_rvalid arrives 1 cycle after rst release -> no rvalid on either requester, all outputs 0 during reset, next grant normal.

Source files
------------

// File: rtl/ysyx_22040127_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22040127_mem_arbiter
//
// Purpose: shares one memory port between a read-only instruction-fetch (IF)
// requester and a read/write data (D) requester. Only one transaction is
// outstanding at a time. The controller moves through IDLE -> ISSUE -> WAIT
// and then back to IDLE.
//
// Transaction flow:
//   IDLE  : pick an owner, latch its fields, and pulse that owner's gnt for
//           that one cycle.
//   ISSUE : drive mem_req with the latched fields until mem_gnt.
//   WAIT  : hold until mem_rvalid. If mem_rvalid never arrives, the
//           transaction ends in an error completion after TIMEOUT_CYC cycles.
//           The timeout counts cycles spent in ISSUE and WAIT together.
//
// Parameters:
//   TIMEOUT_CYC : cycles in ISSUE+WAIT before an error completion
//   AW          : address width
//
// Ports:
//   clk, rst                          clock (rising edge); async active-high reset
//   if_req/if_addr                    fetch request (read only)
//   if_gnt/if_rvalid/if_rdata/if_err  fetch grant and completion
//   d_req/d_we/d_addr/d_wdata/d_wmask data request (read or write)
//   d_gnt/d_rvalid/d_rdata/d_err      data grant and completion
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wmask  shared memory request
//   mem_gnt/mem_rvalid/mem_rdata      shared memory handshake and response
//
// Configuration macro:
//   YSYX_22040127_ARB_RR_EN : when defined, simultaneous requests alternate,
//                             preferring the requester not granted last.
//                             When undefined, the data requester has fixed
//                             priority.
// ---------------------------------------------------------------------------
module ysyx_22040127_mem_arbiter #(
    parameter int TIMEOUT_CYC = 255,
    parameter int AW          = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [63:0]   if_rdata,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [63:0]   d_wdata,
    input  logic [7:0]    d_wmask,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [63:0]   d_rdata,
    output logic          d_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [63:0]   mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [63:0]   mem_rdata
);

    // The counter must hold TIMEOUT_CYC and is never narrower than 8 bits.
    localparam int CW_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYC);

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [7:0]      wmask_q, wmask_d;

    logic            pick_d_s;
    logic            grant_s;
    logic            timeout_s;
    logic            done_ok_s;
    logic            done_err_s;
    logic            done_s;

`ifdef YSYX_22040127_ARB_RR_EN
    // The pointer records the last owner granted. It resets to IF, so the
    // first contended grant goes to the data requester.
    logic            rr_q, rr_d;

    // Alternating arbitration: on contention, pick the requester not granted last.
    always_comb begin
        pick_d_s = 1'b0;
        if (if_req && d_req) begin
            pick_d_s = (rr_q == OWN_IF);
        end else begin
            pick_d_s = d_req;
        end
    end
`else
    // Fixed-priority arbitration: the data requester wins any contention.
    always_comb begin
        pick_d_s = d_req;
    end
`endif

    // Derived control: grant qualification, timeout, and completion.
    // The grant is gated by rst so that every output stays low while reset is
    // held, even if requesters keep their req asserted.
    always_comb begin
        grant_s    = (state_q == ST_IDLE) && (if_req || d_req) && !rst;
        timeout_s  = (state_q != ST_IDLE) && (cnt_q == CNT_LIMIT);
        done_ok_s  = (state_q == ST_WAIT) && mem_rvalid;
        done_err_s = timeout_s && !done_ok_s;
        done_s     = done_ok_s || done_err_s;
    end

    // Next-state logic, latching of the winner's fields, and counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
`ifdef YSYX_22040127_ARB_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Clearing here means the counter reads 0 in the first ISSUE cycle.
                cnt_d = {CW{1'b0}};
                if (grant_s) begin
                    state_d = ST_ISSUE;
                    owner_d = pick_d_s;
`ifdef YSYX_22040127_ARB_RR_EN
                    rr_d    = pick_d_s;
`endif
                    if (pick_d_s) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        wmask_d = d_wmask;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = d_wdata;
                        wmask_d = 8'h00;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (timeout_s) begin
                    state_d = ST_IDLE;
                end else if (mem_gnt) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and transaction registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= {AW{1'b0}};
            wdata_q <= 64'h0;
            wmask_q <= 8'h00;
`ifdef YSYX_22040127_ARB_RR_EN
            rr_q    <= OWN_IF;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
`ifdef YSYX_22040127_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Requester-facing and memory-facing outputs.
    // rdata follows mem_rdata and is qualified only by rvalid. The one
    // exception is an error completion, where rdata is forced to 0.
    always_comb begin
        if_gnt    = grant_s && !pick_d_s;
        d_gnt     = grant_s && pick_d_s;
        if_rvalid = done_s && (owner_q == OWN_IF);
        d_rvalid  = done_s && (owner_q == OWN_D);
        if_err    = done_err_s && (owner_q == OWN_IF);
        d_err     = done_err_s && (owner_q == OWN_D);
        if (done_err_s) begin
            if_rdata = 64'h0;
            d_rdata  = 64'h0;
        end else begin
            if_rdata = mem_rdata;
            d_rdata  = mem_rdata;
        end
        mem_req   = (state_q == ST_ISSUE);
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wmask = wmask_q;
    end

endmodule
